// File: rtl/fifo_control.sv
// ============================================================================
// Module      : fifo_control
// Description : Pointer and flag controller for an 8-entry dual-port memory.
//               Turns producer push / consumer pop requests into the memory's
//               write/read enables and addresses, tracks occupancy and raises
//               full/empty, almost-full/almost-empty and sticky error flags.
//
// Ports
//   clk          in   1             rising-edge clock shared with the memory
//   reset        in   1             asynchronous, active-low reset
//   push         in   1             producer write request
//   pop          in   1             consumer read request
//   umbral_alto  in   ADDR_WIDTH+1  almost-full threshold  (count >= value)
//   umbral_bajo  in   ADDR_WIDTH+1  almost-empty threshold (count <= value)
//   write        out  1             memory write enable (push & ~full)
//   read         out  1             memory read enable  (pop & ~empty)
//   ptr_write    out  ADDR_WIDTH    memory write address
//   ptr_read     out  ADDR_WIDTH    memory read address
//   count        out  ADDR_WIDTH+1  occupancy, 0..LENGTH
//   full / empty / almost_full / almost_empty  out 1  occupancy flags
//   overflow     out  1             sticky: push seen while full
//   underflow    out  1             sticky: pop seen while empty
//
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_control #(
  parameter int ADDR_WIDTH = 3,
  parameter int LENGTH     = 8
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  push,
  input  logic                  pop,
  input  logic [ADDR_WIDTH:0]   umbral_alto,
  input  logic [ADDR_WIDTH:0]   umbral_bajo,
  output logic                  write,
  output logic                  read,
  output logic [ADDR_WIDTH-1:0] ptr_write,
  output logic [ADDR_WIDTH-1:0] ptr_read,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic                  almost_empty,
  output logic                  overflow,
  output logic                  underflow
);

  localparam logic [ADDR_WIDTH:0]   c_length    = (ADDR_WIDTH+1)'(LENGTH);
  localparam logic [ADDR_WIDTH:0]   c_count_one = (ADDR_WIDTH+1)'(1);
  localparam logic [ADDR_WIDTH-1:0] c_ptr_one   = ADDR_WIDTH'(1);

  logic [ADDR_WIDTH-1:0] r_ptr_write;
  logic [ADDR_WIDTH-1:0] r_ptr_read;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_overflow;
  logic                  r_underflow;

  logic                  w_full;
  logic                  w_empty;
  logic                  w_write;
  logic                  w_read;
  logic [ADDR_WIDTH:0]   w_count_next;

  // Flags derive from the registered count only, so they change one cycle
  // after the edge that accepted the transfer.
  assign w_full  = (r_count == c_length);
  assign w_empty = (r_count == '0);

  // At full a simultaneous pop is accepted but the push is not (no bypass);
  // at empty the push is accepted but the pop is not (no fall-through).
  assign w_write = push & ~w_full;
  assign w_read  = pop  & ~w_empty;

  always_comb begin
    w_count_next = r_count;
    if (w_write && !w_read) begin
      w_count_next = r_count + c_count_one;
    end else if (w_read && !w_write) begin
      w_count_next = r_count - c_count_one;
    end
  end

  // Pointers wrap naturally because LENGTH == 2**ADDR_WIDTH.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr_write <= '0;
      r_ptr_read  <= '0;
      r_count     <= '0;
      r_overflow  <= 1'b0;
      r_underflow <= 1'b0;
    end else begin
      if (w_write) begin
        r_ptr_write <= r_ptr_write + c_ptr_one;
      end
      if (w_read) begin
        r_ptr_read <= r_ptr_read + c_ptr_one;
      end
      r_count <= w_count_next;
      if (push && w_full) begin
        r_overflow <= 1'b1;
      end
      if (pop && w_empty) begin
        r_underflow <= 1'b1;
      end
    end
  end

  assign write        = w_write;
  assign read         = w_read;
  assign ptr_write    = r_ptr_write;
  assign ptr_read     = r_ptr_read;
  assign count        = r_count;
  assign full         = w_full;
  assign empty        = w_empty;
  // Thresholds above LENGTH are legal: almost_full then never asserts and
  // almost_empty always does, which falls out of the plain comparisons.
  assign almost_full  = (r_count >= umbral_alto);
  assign almost_empty = (r_count <= umbral_bajo);
  assign overflow     = r_overflow;
  assign underflow    = r_underflow;

endmodule

`default_nettype wire

// File: tb/tb_fifo_control.sv
// ============================================================================
// Module      : tb_fifo_control
// Description : Directed self-checking bench for fifo_control.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_control;

  logic       clk;
  logic       reset;
  logic       push;
  logic       pop;
  logic [3:0] umbral_alto;
  logic [3:0] umbral_bajo;
  logic       write;
  logic       read;
  logic [2:0] ptr_write;
  logic [2:0] ptr_read;
  logic [3:0] count;
  logic       full;
  logic       empty;
  logic       almost_full;
  logic       almost_empty;
  logic       overflow;
  logic       underflow;

  int tests;
  int fails;

  fifo_control #(
    .ADDR_WIDTH (3),
    .LENGTH     (8)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .push         (push),
    .pop          (pop),
    .umbral_alto  (umbral_alto),
    .umbral_bajo  (umbral_bajo),
    .write        (write),
    .read         (read),
    .ptr_write    (ptr_write),
    .ptr_read     (ptr_read),
    .count        (count),
    .full         (full),
    .empty        (empty),
    .almost_full  (almost_full),
    .almost_empty (almost_empty),
    .overflow     (overflow),
    .underflow    (underflow)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int obs, input int exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  // Advance to 1 time unit after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_state(input string tag);
    chk({tag, " ptr_write"}, int'(ptr_write), 0);
    chk({tag, " ptr_read"},  int'(ptr_read),  0);
    chk({tag, " count"},     int'(count),     0);
    chk({tag, " empty"},     int'(empty),     1);
    chk({tag, " full"},      int'(full),      0);
    chk({tag, " overflow"},  int'(overflow),  0);
    chk({tag, " underflow"}, int'(underflow), 0);
    chk({tag, " write"},     int'(write),     0);
    chk({tag, " read"},      int'(read),      0);
  endtask

  // Asynchronous reset pulse placed away from any clock edge.
  task automatic pulse_reset();
    push  = 1'b0;
    pop   = 1'b0;
    #1;
    reset = 1'b0;
    #1;
    reset = 1'b1;
    tick();
  endtask

  task automatic push_n(input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b1;
      pop  = 1'b0;
      tick();
    end
    push = 1'b0;
  endtask

  task automatic pop_n(input int n);
    for (int i = 0; i < n; i++) begin
      push = 1'b0;
      pop  = 1'b1;
      tick();
    end
    pop = 1'b0;
  endtask

  initial begin
    tests       = 0;
    fails       = 0;
    reset       = 1'b0;
    push        = 1'b0;
    pop         = 1'b0;
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;

    // ---------------- reset held for two cycles, then released
    tick();
    tick();
    chk_reset_state("rst_held");
    chk("rst_held almost_empty", int'(almost_empty), 1);
    chk("rst_held almost_full",  int'(almost_full),  0);
    reset = 1'b1;
    #1;
    chk_reset_state("rst_released");

    // ---------------- fill to full (umbral_alto = 6)
    tick();
    for (int i = 0; i < 8; i++) begin
      push = 1'b1;
      #1;
      chk("fill write",     int'(write),     1);
      chk("fill ptr_write", int'(ptr_write), i);
      tick();
      chk("fill count",       int'(count),       i + 1);
      chk("fill almost_full", int'(almost_full), (i + 1 >= 6) ? 1 : 0);
      chk("fill full",        int'(full),        (i + 1 == 8) ? 1 : 0);
    end
    chk("fill ptr_write wrap", int'(ptr_write), 0);
    chk("fill overflow pre",   int'(overflow),  0);
    #1;
    chk("push9 write", int'(write), 0);
    tick();
    chk("push9 overflow", int'(overflow), 1);
    chk("push9 count",    int'(count),    8);
    chk("push9 ptr_write", int'(ptr_write), 0);

    // ---------------- drain to empty (umbral_bajo = 2)
    push = 1'b0;
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      #1;
      chk("drain read",     int'(read),     1);
      chk("drain ptr_read", int'(ptr_read), i);
      tick();
      chk("drain count",        int'(count),        7 - i);
      chk("drain almost_empty", int'(almost_empty), (7 - i <= 2) ? 1 : 0);
      chk("drain empty",        int'(empty),        (i == 7) ? 1 : 0);
    end
    chk("drain ptr_read wrap", int'(ptr_read),  0);
    chk("drain underflow pre", int'(underflow), 0);
    #1;
    chk("pop9 read", int'(read), 0);
    tick();
    chk("pop9 underflow", int'(underflow), 1);
    chk("pop9 count",     int'(count),     0);
    chk("sticky overflow", int'(overflow), 1);

    // ---------------- asynchronous reset mid-run with count = 5
    pulse_reset();
    push_n(5);
    chk("mid count5", int'(count), 5);
    #2;
    reset = 1'b0;
    #1;
    chk_reset_state("mid_rst");
    reset = 1'b1;
    tick();

    // ---------------- streaming: one push, then push=pop for 10 cycles
    push_n(1);
    for (int i = 0; i < 10; i++) begin
      push = 1'b1;
      pop  = 1'b1;
      #1;
      chk("stream write",     int'(write),     1);
      chk("stream read",      int'(read),      1);
      chk("stream ptr_write", int'(ptr_write), (1 + i) % 8);
      chk("stream ptr_read",  int'(ptr_read),  i % 8);
      tick();
      chk("stream count", int'(count), 1);
      chk("stream empty", int'(empty), 0);
      chk("stream full",  int'(full),  0);
      chk("stream almost_empty", int'(almost_empty), 1);
      chk("stream almost_full",  int'(almost_full),  0);
    end
    chk("stream ptr_write end", int'(ptr_write), 3);
    chk("stream ptr_read end",  int'(ptr_read),  2);
    chk("stream overflow",  int'(overflow),  0);
    chk("stream underflow", int'(underflow), 0);

    // ---------------- push+pop at full
    pulse_reset();
    push_n(8);
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("full_pp read",  int'(read),  1);
    chk("full_pp write", int'(write), 0);
    tick();
    chk("full_pp overflow",  int'(overflow),  1);
    chk("full_pp count",     int'(count),     7);
    chk("full_pp ptr_read",  int'(ptr_read),  1);
    chk("full_pp ptr_write", int'(ptr_write), 0);
    chk("full_pp underflow", int'(underflow), 0);

    // ---------------- push+pop at empty
    pulse_reset();
    push = 1'b1;
    pop  = 1'b1;
    #1;
    chk("empty_pp write", int'(write), 1);
    chk("empty_pp read",  int'(read),  0);
    tick();
    chk("empty_pp underflow", int'(underflow), 1);
    chk("empty_pp count",     int'(count),     1);
    chk("empty_pp ptr_write", int'(ptr_write), 1);
    chk("empty_pp ptr_read",  int'(ptr_read),  0);
    chk("empty_pp overflow",  int'(overflow),  0);

    // ---------------- wrap integrity: push 5, pop 3, push 6
    pulse_reset();
    push_n(5);
    pop_n(3);
    push_n(6);
    chk("wrap ptr_write", int'(ptr_write), 3);
    chk("wrap ptr_read",  int'(ptr_read),  3);
    chk("wrap count",     int'(count),     8);
    chk("wrap full",      int'(full),      1);
    // Thresholds above LENGTH
    umbral_alto = 4'd9;
    umbral_bajo = 4'd15;
    #1;
    chk("thr_hi almost_full",  int'(almost_full),  0);
    chk("thr_hi almost_empty", int'(almost_empty), 1);
    umbral_alto = 4'd6;
    umbral_bajo = 4'd2;
    // Data 4..11 sits at addresses 3,4,5,6,7,0,1,2
    for (int i = 0; i < 8; i++) begin
      pop = 1'b1;
      #1;
      chk("wrap read",     int'(read),     1);
      chk("wrap ptr_read", int'(ptr_read), (i + 3) % 8);
      tick();
    end
    pop = 1'b0;
    chk("wrap drained empty", int'(empty), 1);
    chk("wrap overflow",      int'(overflow),  0);
    chk("wrap underflow",     int'(underflow), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  // Guard against a stalled run.
  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire

// File: doc/fifo_control.md
Name: fifo_control

Overview:
- Pointer and flag controller that sits directly upstream of the 8-entry, 10-bit dual-port memory.
- Converts push/pop requests from the producer/consumer into the memory's write, read, ptr_write and ptr_read controls.
- Tracks occupancy and raises full/empty, almost-full/almost-empty and sticky error flags.
- The memory plus this block together form a FIFO.

Parameters:
- ADDR_WIDTH, 3, pointer width; depth is 2**ADDR_WIDTH.
- LENGTH, 8, FIFO depth; must equal 2**ADDR_WIDTH.

Ports:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, named reset.
- clk  input  1  rising-edge clock shared with the memory.
- reset  input  1  asynchronous, active-low reset.
- push  input  1  producer requests a write this cycle.
- pop  input  1  consumer requests a read this cycle.
- umbral_alto  input  ADDR_WIDTH+1  almost-full threshold.
- umbral_bajo  input  ADDR_WIDTH+1  almost-empty threshold.
- write  output  1  memory write enable.
- read  output  1  memory read enable.
- ptr_write  output  ADDR_WIDTH  memory write address.
- ptr_read  output  ADDR_WIDTH  memory read address.
- count  output  ADDR_WIDTH+1  occupancy, 0..LENGTH.
- full  output  1  count == LENGTH.
- empty  output  1  count == 0.
- almost_full  output  1  count >= umbral_alto.
- almost_empty  output  1  count <= umbral_bajo.
- overflow  output  1  sticky: push attempted while full.
- underflow  output  1  sticky: pop attempted while empty.

Behaviour:
- Reset (reset==0, asynchronous, any time including mid-transfer):
  - ptr_write=0, ptr_read=0, count=0; overflow=0, underflow=0.
  - Therefore empty=1, full=0, write=0, read=0.
  - almost_empty = (0 <= umbral_bajo); almost_full = (0 >= umbral_alto).
  - In-flight requests are discarded.
- State registers: ptr_write, ptr_read, count, overflow, underflow. No other state.
- Accept logic (combinational from current registers and inputs):
  - write = push & ~full.
  - read = pop & ~empty.
  - write/read are valid in the same cycle as push/pop, so the memory samples ptr_write/ptr_read at that same edge.
- At each rising edge with reset==1:
  - write=1 -> ptr_write increments by 1, mod LENGTH (LENGTH-1 wraps to 0).
  - read=1 -> ptr_read increments by 1, mod LENGTH.
  - count: +1 if write & ~read; -1 if read & ~write; unchanged if both or neither.
  - push & full -> overflow set to 1; stays 1 until reset.
  - pop & empty -> underflow set to 1; stays 1 until reset.
- Simultaneous push and pop:
  - Not full and not empty: both accepted; count unchanged; both pointers advance.
  - Full: pop accepted, push rejected (no same-address bypass); overflow set; count becomes LENGTH-1.
  - Empty: push accepted, pop rejected (no fall-through); underflow set; count becomes 1.
- Flags:
  - full, empty, almost_full, almost_empty are combinational from the registered count and the threshold inputs. They update in the cycle after the accepting edge.
  - Threshold values above LENGTH are legal: almost_full stays 0; almost_empty stays 1.
- Invariant: ptr_write - ptr_read (mod LENGTH) == count mod LENGTH at all times; full implies ptr_write == ptr_read.
- Latency: a word pushed at edge N is visible to a pop from edge N+1 onward (memory read latency is the memory's own).

Test Plan:
- Reset check: hold reset=0 for 2 cycles, then release -> ptr_write=0, ptr_read=0, count=0, empty=1, full=0, overflow=0, underflow=0. Assert reset mid-run with count=5 -> all return to reset values immediately, without waiting for a clock edge.
- Fill to full: push=1 for 8 cycles, data 1..8, umbral_alto=6 -> write=1 each cycle; ptr_write 0..7 then wraps to 0; almost_full=1 once count=6; full=1 at count=8; a 9th push gives write=0 and overflow=1, and count stays 8.
- Drain to empty: from full, pop=1 for 8 cycles, umbral_bajo=2 -> read=1, ptr_read 0..7 then 0; data_out 1..8 in order; almost_empty=1 at count=2; empty=1 at count=0; a 9th pop gives read=0 and underflow=1.
- Streaming: after one push, push=pop=1 for 10 cycles -> count stays 1; both pointers advance each cycle and wrap past 7; no flags change.
- Boundary simultaneity: at full, push=pop=1 -> read=1, write=0, overflow=1, count=7. At empty, push=pop=1 -> write=1, read=0, underflow=1, count=1.
- Wrap integrity: push 5 (data 1..5), pop 3, push 6 (data 6..11) -> ptr_write=3, ptr_read=3, count=8, full=1; the following reads return 4,5,6,...,11 in order.
